// File: rtl/pulse_train.sv
// Pulse-train generator: emits bursts of count pulses, or a continuous train
// until stop. Each pulse is max(high_len,1) cycles high followed by
// max(low_len,1) cycles low. Every output comes straight from a flop.
module pulse_train #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  input  logic         mode,
  input  logic [W-1:0] high_len,
  input  logic [W-1:0] low_len,
  input  logic [W-1:0] count,
  output logic         signal,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] pulses
);

  typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

  state_e       state_q, state_d;
  logic [W-1:0] timer_q, timer_d;
  // Phase lengths are stored as (effective length - 1) so the timer can
  // count down to zero and a programmed 0 behaves like 1.
  logic [W-1:0] hm1_q, hm1_d;
  logic [W-1:0] lm1_q, lm1_d;
  logic [W-1:0] count_q, count_d;
  logic         mode_q, mode_d;
  logic [W-1:0] pulses_q, pulses_d;
  logic         signal_q, signal_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic         accept;
  logic         empty_burst;
  logic         burst_end;
  logic         pulse_inc;
  logic [W-1:0] start_hm1;
  logic [W-1:0] start_lm1;

  assign start_hm1 = (high_len == '0) ? '0 : high_len - 1'b1;
  assign start_lm1 = (low_len == '0) ? '0 : low_len - 1'b1;

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      timer_q  <= '0;
      hm1_q    <= '0;
      lm1_q    <= '0;
      count_q  <= '0;
      mode_q   <= 1'b0;
      pulses_q <= '0;
      signal_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      hm1_q    <= hm1_d;
      lm1_q    <= lm1_d;
      count_q  <= count_d;
      mode_q   <= mode_d;
      pulses_q <= pulses_d;
      signal_q <= signal_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state, phase timer and configuration latching.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    hm1_d       = hm1_q;
    lm1_d       = lm1_q;
    count_d     = count_q;
    mode_d      = mode_q;
    accept      = 1'b0;
    empty_burst = 1'b0;
    burst_end   = 1'b0;
    pulse_inc   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // stop overrides start here.
        if (start && !stop) begin
          if (mode || (count != '0)) begin
            accept  = 1'b1;
            hm1_d   = start_hm1;
            lm1_d   = start_lm1;
            count_d = count;
            mode_d  = mode;
            timer_d = start_hm1;
            state_d = StHigh;
          end else begin
            empty_burst = 1'b1;
          end
        end
      end
      StHigh: begin
        if (stop) begin
          state_d = StIdle;
        end else if (timer_q == '0) begin
          pulse_inc = 1'b1;
          timer_d   = lm1_q;
          state_d   = StLow;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      StLow: begin
        if (stop) begin
          state_d = StIdle;
        end else if (timer_q == '0) begin
          // pulses_q already includes the high phase that just finished.
          if (!mode_q && (pulses_q == count_q)) begin
            burst_end = 1'b1;
            state_d   = StIdle;
          end else begin
            timer_d = hm1_q;
            state_d = StHigh;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    signal_d = (state_d == StHigh);
    busy_d   = (state_d != StIdle);
    done_d   = empty_burst | burst_end;
    pulses_d = pulses_q;
    if (accept) begin
      pulses_d = '0;
    end else if (pulse_inc) begin
      pulses_d = pulses_q + 1'b1;
    end
  end

  assign signal = signal_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign pulses = pulses_q;

endmodule

// File: doc/pulse_train.md
PULSE_TRAIN -- requirements
Module: pulse_train

Interface
REQ-001 SHALL have parameter W, default 8, width of the length, count and pulse-counter fields.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin a burst; sampled only in IDLE.
REQ-005 stop  input  1  abort request; sampled in every state.
REQ-006 mode  input  1  0 = burst of count pulses, 1 = continuous until stop.
REQ-007 high_len  input  W  high-phase length in cycles (0 treated as 1).
REQ-008 low_len  input  W  low-phase length in cycles (0 treated as 1).
REQ-009 count  input  W  number of pulses in burst mode.
REQ-010 signal  output  1  registered pulse-train output.
REQ-011 busy  output  1  high while a train is running.
REQ-012 done  output  1  one-cycle strobe at burst completion.
REQ-013 pulses  output  W  completed high phases since the last accepted start, mod 2^W.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, HIGH, LOW. All outputs SHALL be registered.
REQ-015 In IDLE with start=1, stop=0, count!=0 or mode=1: latch high_len, low_len, count and mode; clear pulses; go to HIGH with signal=1 and busy=1 from the following cycle.
REQ-016 In IDLE with start=1, stop=0, mode=0, count=0: stay in IDLE, keep signal=0 and busy=0, and pulse done=1 for one cycle.
REQ-017 HIGH SHALL last exactly max(high_len,1) cycles with signal=1; then go to LOW with signal=0 and increment pulses.
REQ-018 LOW SHALL last exactly max(low_len,1) cycles with signal=0.
REQ-019 At the end of LOW in burst mode, if pulses equals the latched count, go to IDLE with busy=0 and done=1 for one cycle; otherwise go to HIGH.
REQ-020 At the end of LOW in continuous mode, always go to HIGH; the latched count SHALL be ignored.
REQ-021 A burst SHALL therefore keep busy high for exactly N*(H+L) cycles, where N, H and L are the latched count and effective lengths.
REQ-022 Input changes to high_len, low_len, count or mode while busy SHALL have no effect until the next accepted start.
REQ-023 start while busy SHALL be ignored.
REQ-024 start in the cycle done=1 (already IDLE) SHALL be accepted normally.
REQ-025 stop=1 in HIGH or LOW: at the next edge go to IDLE with signal=0 and busy=0; done SHALL NOT be asserted; pulses holds its value.
REQ-026 stop=1 with start=1 in IDLE: stop wins; no train starts and done stays 0.
REQ-027 The pulses counter SHALL wrap from 2^W-1 to 0 in continuous mode.
REQ-028 Phase timers SHALL be W bits wide; with W=8, a length of 255 is the maximum and SHALL be honoured exactly.

Reset
REQ-029 With reset=1 at a rising edge: state=IDLE, signal=0, busy=0, done=0, pulses=0, all latched fields and timers cleared.
REQ-030 Reset SHALL take priority over start and stop.
REQ-031 Reset mid-train SHALL abort the train at that edge without asserting done.

Verification
REQ-032 Burst (H=2, L=3, N=2, start sampled at edge 0): signal=1 after edges 0-1, 0 after 2-4, 1 after 5-6, 0 after 7-9; busy=1 after edges 0-9; done=1 only after edge 10; pulses ends at 2.
REQ-033 Zero lengths (H=0, L=0, N=3): signal alternates 1,0 for 6 cycles; done follows.
REQ-034 count=0, mode=0: done=1 for one cycle, signal and busy never rise.
REQ-035 Continuous (H=1, L=1, mode=1, W=8): run 300 pulses, then assert stop; pulses wraps 255->0 and reads 44; signal=0 and busy=0 after the stop edge; done never asserted.
REQ-036 Abort/reset: stop at cycle 3 of the HIGH phase -> IDLE on the next edge; reset asserted mid-LOW -> all outputs 0 on the next edge.
REQ-037 Ignored/back-to-back start: start held while busy (with high_len changed) -> no restart and original timing kept; start in the done cycle -> new train begins on the next edge.
